pool_relu_nch: RTL and testbench

- Parametrised successor to the fixed 3-channel max-pool/ReLU stage of the CNN pipeline.
- Streaming 2x2 stride-2 pooling over NUM_CH parallel feature-map channels, in raster order, with a selectable pooling mode (max or average) and an optional ReLU.
- Sits between any conv layer and the next conv or fully-connected layer. One pooled pixel per channel is produced every time a 2x2 window completes.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/pool_lane.sv | 75 +++++++
 rtl/pool_relu_nch.sv | 104 ++++++++++
 tb/tb_pool_relu_nch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: pooling-mode encodings and the
// counter-width helper used for feature-map coordinate counters.
package cnn_pkg;

    localparam int POOL_MAX = 0;
    localparam int POOL_AVG = 1;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pool_lane.sv
// Single-channel 2x2/stride-2 pooling datapath: pair register, line buffer,
// max/average reduction, optional ReLU and registered output.
// Ports: clk, rst_n, pix_en_i (pixel accepted), col_odd_i, row_odd_i,
//        idx_i (line-buffer entry = col>>1), pix_i (sample), data_o (result).
module pool_lane
    import cnn_pkg::*;
#(
    parameter int DATA_BIT  = 12,
    parameter int WIDTH     = 24,
    parameter int POOL_MODE = POOL_MAX,
    parameter int RELU_EN   = 1,
    parameter int IDX_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_en_i,
    input  logic                       col_odd_i,
    input  logic                       row_odd_i,
    input  logic [IDX_W-1:0]           idx_i,
    input  logic signed [DATA_BIT-1:0] pix_i,
    output logic signed [DATA_BIT-1:0] data_o
);

    localparam int HW  = DATA_BIT + 1;
    localparam int SW  = DATA_BIT + 2;
    localparam int ENT = WIDTH / 2;

    logic signed [DATA_BIT-1:0] left_q;
    logic signed [HW-1:0]       lb_q [ENT];
    logic signed [DATA_BIT-1:0] data_q, data_d;

    logic signed [HW-1:0] left_x, cur_x, h, lb;
    logic signed [SW-1:0] sum, shr;
    logic signed [HW-1:0] mx;
    logic signed [DATA_BIT-1:0] r;

    always_comb begin
        left_x = {left_q[DATA_BIT-1], left_q};
        cur_x  = {pix_i[DATA_BIT-1], pix_i};
        lb     = lb_q[idx_i];
        if (POOL_MODE == POOL_AVG) h = left_x + cur_x;
        else h = (cur_x > left_x) ? cur_x : left_x;

        sum = {lb[HW-1], lb} + {h[HW-1], h};
        shr = sum >>> 2;
        mx  = (h > lb) ? h : lb;

        // Both reductions fit DATA_BIT: max picks a sample, and the
        // floored mean of four samples stays within the sample range.
        if (POOL_MODE == POOL_AVG) r = shr[DATA_BIT-1:0];
        else r = mx[DATA_BIT-1:0];

        data_d = r;
        if (RELU_EN != 0 && r[DATA_BIT-1]) data_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q <= '0;
            data_q <= '0;
        end else if (pix_en_i) begin
            if (!col_odd_i) left_q <= pix_i;
            if (col_odd_i && row_odd_i) data_q <= data_d;
        end
    end

    // Line buffer holds the even-row horizontal result; no reset needed
    // because every entry is rewritten before an odd row reads it.
    always_ff @(posedge clk) begin
        if (pix_en_i && col_odd_i && !row_odd_i) lb_q[idx_i] <= h;
    end

    assign data_o = data_q;

endmodule

// File: rtl/pool_relu_nch.sv
// NUM_CH-channel streaming 2x2/stride-2 pool (max or average) with ReLU.
// Ports: clk, rst_n, sof, valid_in, data_in (packed channels),
//        data_out (packed), valid_out, frame_done.
module pool_relu_nch
    import cnn_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int DATA_BIT  = 12,
    parameter int WIDTH     = 24,
    parameter int HEIGHT    = 24,
    parameter int POOL_MODE = POOL_MAX,
    parameter int RELU_EN   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sof,
    input  logic                       valid_in,
    input  logic [NUM_CH*DATA_BIT-1:0] data_in,
    output logic [NUM_CH*DATA_BIT-1:0] data_out,
    output logic                       valid_out,
    output logic                       frame_done
);

    localparam int CW = cnt_w(WIDTH);
    localparam int RW = cnt_w(HEIGHT);
    localparam int IW = cnt_w(WIDTH / 2);

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("pool_relu_nch: WIDTH must be even and >= 2");
    end
    if (HEIGHT < 2 || (HEIGHT % 2) != 0) begin : g_bad_height
        $error("pool_relu_nch: HEIGHT must be even and >= 2");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $error("pool_relu_nch: NUM_CH must be >= 1");
    end

    logic [CW-1:0] col_q, col_d, col_e;
    logic [RW-1:0] row_q, row_d, row_e;
    logic          last_col, last_row, fire;
    logic          valid_q, done_q;
    logic [IW-1:0] idx;

    // sof re-anchors the current pixel at (0,0); a stale partial window
    // is dropped because row 0 rewrites every line-buffer entry first.
    always_comb begin
        col_e    = (sof && valid_in) ? '0 : col_q;
        row_e    = (sof && valid_in) ? '0 : row_q;
        last_col = (col_e == CW'(WIDTH - 1));
        last_row = (row_e == RW'(HEIGHT - 1));
        fire     = valid_in && col_e[0] && row_e[0];
        idx      = IW'(col_e >> 1);
        col_d    = col_q;
        row_d    = row_q;
        if (valid_in) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_e + RW'(1);
            end else begin
                col_d = col_e + CW'(1);
                row_d = row_e;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= fire;
            done_q  <= fire && last_col && last_row;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic [DATA_BIT-1:0] lane_out;
        pool_lane #(
            .DATA_BIT (DATA_BIT),
            .WIDTH    (WIDTH),
            .POOL_MODE(POOL_MODE),
            .RELU_EN  (RELU_EN),
            .IDX_W    (IW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .pix_en_i (valid_in),
            .col_odd_i(col_e[0]),
            .row_odd_i(row_e[0]),
            .idx_i    (idx),
            .pix_i    (data_in[c*DATA_BIT +: DATA_BIT]),
            .data_o   (lane_out)
        );
        assign data_out[c*DATA_BIT +: DATA_BIT] = lane_out;
    end

    assign valid_out  = valid_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pool_relu_nch.sv
// Bench for pool_relu_nch: four configurations on one shared 4x4 stream,
// compared against a window-level reference model every cycle.
module tb_pool_relu_nch;

    localparam int NC = 3;
    localparam int DB = 12;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NCFG = 4;

    logic clk = 1'b0;
    logic rst_n, sof, valid_in;
    logic [NC*DB-1:0] data_in;
    logic [NC*DB-1:0] dout [NCFG];
    logic vo [NCFG];
    logic fd [NCFG];

    always #5 clk = ~clk;

    // cfg0 max/relu, cfg1 avg/no-relu, cfg2 avg/relu, cfg3 max/no-relu
    pool_relu_nch #(.NUM_CH(NC), .DATA_BIT(DB), .WIDTH(W), .HEIGHT(H),
                    .POOL_MODE(0), .RELU_EN(1)) u0 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(valid_in),
        .data_in(data_in), .data_out(dout[0]), .valid_out(vo[0]),
        .frame_done(fd[0]));
    pool_relu_nch #(.NUM_CH(NC), .DATA_BIT(DB), .WIDTH(W), .HEIGHT(H),
                    .POOL_MODE(1), .RELU_EN(0)) u1 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(valid_in),
        .data_in(data_in), .data_out(dout[1]), .valid_out(vo[1]),
        .frame_done(fd[1]));
    pool_relu_nch #(.NUM_CH(NC), .DATA_BIT(DB), .WIDTH(W), .HEIGHT(H),
                    .POOL_MODE(1), .RELU_EN(1)) u2 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(valid_in),
        .data_in(data_in), .data_out(dout[2]), .valid_out(vo[2]),
        .frame_done(fd[2]));
    pool_relu_nch #(.NUM_CH(NC), .DATA_BIT(DB), .WIDTH(W), .HEIGHT(H),
                    .POOL_MODE(0), .RELU_EN(0)) u3 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(valid_in),
        .data_in(data_in), .data_out(dout[3]), .valid_out(vo[3]),
        .frame_done(fd[3]));

    int px [H][W][NC];
    int pin [NC];
    int mcol, mrow;
    bit ev, efd;
    int ed [NCFG][NC];
    int n_chk, n_fail;
    int cnt_v, cnt_fd;
    int cap0[$];
    int cap1[$];

    function automatic int win(int cfg, int r, int c, int ch);
        int v[4];
        int s, res;
        v[0] = px[r-1][c-1][ch];
        v[1] = px[r-1][c][ch];
        v[2] = px[r][c-1][ch];
        v[3] = px[r][c][ch];
        if (cfg == 1 || cfg == 2) begin
            s = v[0] + v[1] + v[2] + v[3];
            res = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        end else begin
            res = v[0];
            for (int i = 1; i < 4; i++) if (v[i] > res) res = v[i];
        end
        if ((cfg == 0 || cfg == 2) && res < 0) res = 0;
        return res;
    endfunction

    task automatic model_reset();
        mcol = 0; mrow = 0; ev = 0; efd = 0;
        for (int g = 0; g < NCFG; g++)
            for (int c = 0; c < NC; c++) ed[g][c] = 0;
    endtask

    task automatic model(input bit s, input bit v);
        ev = 0; efd = 0;
        if (v) begin
            if (s) begin mcol = 0; mrow = 0; end
            for (int c = 0; c < NC; c++) px[mrow][mcol][c] = pin[c];
            ev  = (mcol % 2 == 1) && (mrow % 2 == 1);
            efd = ev && mcol == W - 1 && mrow == H - 1;
            if (ev)
                for (int g = 0; g < NCFG; g++)
                    for (int c = 0; c < NC; c++)
                        ed[g][c] = win(g, mrow, mcol, c);
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else mcol++;
        end
    endtask

    task automatic check();
        logic [DB-1:0] got, want;
        for (int g = 0; g < NCFG; g++) begin
            n_chk++;
            assert (vo[g] === ev) else begin
                n_fail++;
                $error("FAIL valid_out cfg%0d got %0b want %0b", g, vo[g], ev);
            end
            n_chk++;
            assert (fd[g] === efd) else begin
                n_fail++;
                $error("FAIL frame_done cfg%0d got %0b want %0b", g, fd[g], efd);
            end
            for (int c = 0; c < NC; c++) begin
                got  = dout[g][c*DB +: DB];
                want = DB'(ed[g][c]);
                n_chk++;
                assert (got === want) else begin
                    n_fail++;
                    $error("FAIL data_out cfg%0d ch%0d got %h want %h",
                           g, c, got, want);
                end
            end
        end
        if (vo[0] === 1'b1) begin
            cnt_v++;
            cap0.push_back(int'(dout[0][DB-1:0]));
            cap1.push_back(int'(dout[1][DB-1:0]));
        end
        if (fd[0] === 1'b1) cnt_fd++;
    endtask

    task automatic step(input bit s, input bit v);
        sof = s;
        valid_in = v;
        for (int c = 0; c < NC; c++) data_in[c*DB +: DB] = DB'(pin[c]);
        @(posedge clk);
        model(s, v);
        #1 check();
    endtask

    // kind 0: ch0=k ch1=-k ch2=2k; 1: {-1,-2,-1,-1} windows; 2: random
    task automatic feed(input int kind, input int n, input bit s0,
                        input int gap_pct);
        logic signed [DB-1:0] t;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (kind == 0) pin[c] = (c == 0) ? i + 1 :
                                        (c == 1) ? -(i + 1) : 2 * (i + 1);
                else if (kind == 1)
                    pin[c] = ((i / W) % 2 == 0 && i % 2 == 1) ? -2 : -1;
                else begin
                    t = DB'($urandom);
                    pin[c] = int'(t);
                end
            end
            while (gap_pct > 0 && $urandom_range(99) < gap_pct)
                step(bit'($urandom_range(1)), 1'b0);
            step(s0 && i == 0, 1'b1);
        end
    endtask

    task automatic expect_seq(input int got[$], input int e0, input int e1,
                              input int e2, input int e3, input string tag);
        int e[4];
        e = '{e0, e1, e2, e3};
        n_chk++;
        assert (got.size() == 4) else begin
            n_fail++;
            $error("FAIL %s count got %0d want 4", tag, got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_chk++;
            assert (got[i] == e[i]) else begin
                n_fail++;
                $error("FAIL %s[%0d] got %0d want %0d", tag, i, got[i], e[i]);
            end
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cnt_v = 0; cnt_fd = 0;
        rst_n = 1'b0; sof = 1'b0; valid_in = 1'b0; data_in = '0;
        for (int c = 0; c < NC; c++) pin[c] = 0;
        model_reset();
        #1 check();
        @(posedge clk); #1 check();
        rst_n = 1'b1;

        // sequential frame, continuous
        cap0 = {}; cap1 = {};
        feed(0, 16, 1'b1, 0);
        step(1'b0, 1'b0);
        expect_seq(cap0, 6, 8, 14, 16, "max_seq");
        expect_seq(cap1, 3, 5, 11, 13, "avg_seq");

        // negative windows
        feed(1, 16, 1'b1, 0);
        n_chk++;
        assert (dout[1][DB-1:0] === 12'hFFE) else begin
            n_fail++; $error("FAIL neg_avg got %h want ffe", dout[1][DB-1:0]);
        end
        n_chk++;
        assert (dout[2][DB-1:0] === 12'h000) else begin
            n_fail++; $error("FAIL neg_avg_relu got %h want 000", dout[2][DB-1:0]);
        end
        n_chk++;
        assert (dout[3][DB-1:0] === 12'hFFF) else begin
            n_fail++; $error("FAIL neg_max got %h want fff", dout[3][DB-1:0]);
        end

        // sequential frame with gaps, then random frames with gaps
        cap0 = {};
        feed(0, 16, 1'b1, 40);
        expect_seq(cap0, 6, 8, 14, 16, "max_gaps");
        for (int f = 0; f < 4; f++) feed(2, 16, 1'b1, 30);

        // sof mid-frame: partial frame abandoned
        feed(2, 5, 1'b1, 0);
        cap0 = {};
        feed(0, 16, 1'b1, 0);
        expect_seq(cap0, 6, 8, 14, 16, "sof_mid");

        // back-to-back frames, implicit wrap on the second
        cnt_v = 0; cnt_fd = 0;
        feed(2, 16, 1'b1, 0);
        feed(2, 16, 1'b0, 0);
        n_chk++;
        assert (cnt_v == 8) else begin
            n_fail++; $error("FAIL b2b_outputs got %0d want 8", cnt_v);
        end
        n_chk++;
        assert (cnt_fd == 2) else begin
            n_fail++; $error("FAIL b2b_frame_done got %0d want 2", cnt_fd);
        end

        // reset mid third frame
        feed(2, 7, 1'b0, 0);
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 check();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        feed(2, 16, 1'b0, 20);
        feed(2, 16, 1'b1, 0);
        step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
